// File: rtl/rio_udp_pkg.sv
// Shared definitions for the RIO-to-UDP transmit path.
package rio_udp_pkg;

  localparam int unsigned BYTE_W           = 8;
  localparam logic [15:0] DEFAULT_SRC_PORT = 16'd2390;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_LOAD,
    ST_REQ,
    ST_DONE,
    ST_ABORT
  } tx_state_e;

  // Number of whole bytes in a frame of the given bit width.
  function automatic int unsigned nbytes(input int unsigned bits);
    return bits / BYTE_W;
  endfunction

endpackage

// File: rtl/udp_tx_shifter.sv
// MSB-first frame shifter: presents the top byte, shifts one byte per
// accepted transfer and flags when the byte on the output is the last one.
module udp_tx_shifter
  import rio_udp_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [BUFFER_SIZE-1:0] i_frame,
  input  logic                   i_shift,
  output logic [BYTE_W-1:0]      o_byte,
  output logic                   o_last
);

  localparam int unsigned NB = nbytes(BUFFER_SIZE);
  localparam int unsigned CW = $clog2(NB + 1);

  logic [BUFFER_SIZE-1:0] r_sh;
  logic [CW-1:0]          r_cnt;

  // Load a new frame, or drop the top byte once it has been accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_frame;
      r_cnt <= CW'(NB);
    end else if (i_shift && (r_cnt != '0)) begin
      r_sh  <= r_sh << BYTE_W;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_byte = r_sh[BUFFER_SIZE-1 -: BYTE_W];
  assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/udp_tx_framer.sv
// Serialises a reply frame into the UDP core's byte interface, then issues
// the transmit request. A one-deep slot holds a request arriving mid-frame.
module udp_tx_framer
  import rio_udp_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE  = 40,
  parameter logic [15:0] SRC_PORT     = DEFAULT_SRC_PORT,
  parameter int unsigned BYTE_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BUFFER_SIZE-1:0] frame,
  input  logic [31:0]            dst_ip,
  input  logic [15:0]            dst_port,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            tx_ip_o,
  output logic [15:0]            tx_src_port_o,
  output logic [15:0]            tx_dst_port_o,
  output logic                   tx_req_o,
  input  logic                   tx_req_rdy_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_data_av_o,
  input  logic                   tx_data_rdy_i
);

  localparam int unsigned     TO_W    = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BYTE_TIMEOUT - 1);

  tx_state_e r_state, w_next;

  logic                   r_slot_vld;
  logic [BUFFER_SIZE-1:0] r_slot_frame;
  logic [31:0]            r_slot_ip;
  logic [15:0]            r_slot_port;

  logic [31:0]     r_ip;
  logic [15:0]     r_port;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_busy, r_done, r_error, r_req, r_av;

  logic                   w_activate, w_take_start, w_slot_vld_nxt;
  logic                   w_accept, w_last, w_timeout;
  logic [BUFFER_SIZE-1:0] w_load_frame;
  logic [7:0]             w_byte;

  assign w_accept     = r_av && tx_data_rdy_i;
  assign w_timeout    = (r_state == ST_LOAD) && !tx_data_rdy_i && (r_to_cnt == TO_LAST);
  assign w_load_frame = w_take_start ? frame : r_slot_frame;

  udp_tx_shifter #(
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_activate),
    .i_frame(w_load_frame),
    .i_shift(w_accept),
    .o_byte (w_byte),
    .o_last (w_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; a start coinciding with DONE/ABORT is taken straight
  // through the slot (latest wins), so it is loaded directly from the inputs.
  always_comb begin
    w_next       = r_state;
    w_activate   = 1'b0;
    w_take_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next       = ST_WAIT_RDY;
          w_activate   = 1'b1;
          w_take_start = 1'b1;
        end
      end
      ST_WAIT_RDY: if (tx_req_rdy_i) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_accept && w_last) w_next = ST_REQ;
        else if (w_timeout)     w_next = ST_ABORT;
      end
      ST_REQ: if (r_req && tx_req_rdy_i) w_next = ST_DONE;
      ST_DONE, ST_ABORT: begin
        if (start || r_slot_vld) begin
          w_next       = ST_WAIT_RDY;
          w_activate   = 1'b1;
          w_take_start = start;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_activate)                      w_slot_vld_nxt = 1'b0;
    else if (start && r_state != ST_IDLE) w_slot_vld_nxt = 1'b1;
    else                                 w_slot_vld_nxt = r_slot_vld;
  end

  // Registered outputs, pending slot, active addressing and byte timeout.
  // The request is only raised after the core was seen ready, so a core
  // that is not ready in REQ sees no request until it becomes ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_req        <= 1'b0;
      r_av         <= 1'b0;
      r_slot_vld   <= 1'b0;
      r_slot_frame <= '0;
      r_slot_ip    <= '0;
      r_slot_port  <= '0;
      r_ip         <= '0;
      r_port       <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_busy     <= w_slot_vld_nxt ||
                    !(w_next == ST_IDLE || w_next == ST_DONE || w_next == ST_ABORT);
      r_done     <= (w_next == ST_DONE);
      r_error    <= (w_next == ST_ABORT);
      r_av       <= (w_next == ST_LOAD);
      r_req      <= (w_next == ST_REQ) && tx_req_rdy_i;
      r_slot_vld <= w_slot_vld_nxt;
      if (start && r_state != ST_IDLE) begin
        r_slot_frame <= frame;
        r_slot_ip    <= dst_ip;
        r_slot_port  <= dst_port;
      end
      if (w_activate) begin
        r_ip   <= w_take_start ? dst_ip   : r_slot_ip;
        r_port <= w_take_start ? dst_port : r_slot_port;
      end
      if (r_state == ST_LOAD && !tx_data_rdy_i) r_to_cnt <= r_to_cnt + 1'b1;
      else                                      r_to_cnt <= '0;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign tx_ip_o       = r_ip;
  assign tx_src_port_o = SRC_PORT;
  assign tx_dst_port_o = r_port;
  assign tx_req_o      = r_req;
  assign tx_data_o     = w_byte;
  assign tx_data_av_o  = r_av;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Self-checking bench for udp_tx_framer.
module tb_udp_tx_framer;

  localparam int NB = 5;

  logic        clk, rst, start;
  logic [39:0] frame;
  logic [31:0] dst_ip;
  logic [15:0] dst_port;
  logic        busy, done, error;
  logic [31:0] tx_ip_o;
  logic [15:0] tx_src_port_o, tx_dst_port_o;
  logic        tx_req_o, tx_req_rdy_i;
  logic [7:0]  tx_data_o;
  logic        tx_data_av_o, tx_data_rdy_i;

  udp_tx_framer #(
    .BUFFER_SIZE(40),
    .SRC_PORT(16'd2390),
    .BYTE_TIMEOUT(1024)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame(frame), .dst_ip(dst_ip),
    .dst_port(dst_port), .busy(busy), .done(done), .error(error),
    .tx_ip_o(tx_ip_o), .tx_src_port_o(tx_src_port_o), .tx_dst_port_o(tx_dst_port_o),
    .tx_req_o(tx_req_o), .tx_req_rdy_i(tx_req_rdy_i), .tx_data_o(tx_data_o),
    .tx_data_av_o(tx_data_av_o), .tx_data_rdy_i(tx_data_rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction monitor, sampled mid-cycle.
  logic [7:0]  mon_bytes[$];
  int          n_reqacc = 0, n_done = 0, n_err = 0;
  logic [31:0] req_ip   = '0;
  logic [15:0] req_port = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (tx_data_av_o && tx_data_rdy_i) mon_bytes.push_back(tx_data_o);
      if (tx_req_o && tx_req_rdy_i) begin
        n_reqacc <= n_reqacc + 1;
        req_ip   <= tx_ip_o;
        req_port <= tx_dst_port_o;
      end
      if (done)  n_done <= n_done + 1;
      if (error) n_err  <= n_err + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic       st;
    logic       qr;
    logic       dr;
    logic       busy;
    logic       av;
    logic       chk_d;
    logic [7:0] d;
    logic       req;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vt[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference byte k of a frame: MSB-first slicing by arithmetic shift.
  function automatic logic [7:0] exp_byte(input logic [39:0] f, input int k);
    logic [39:0] s;
    s = f >> (8 * (NB - 1 - k));
    return s[7:0];
  endfunction

  task automatic check_bytes(input string nm, input int base, input logic [39:0] f);
    for (int k = 0; k < NB; k++) begin
      if (base + k < mon_bytes.size())
        check($sformatf("%s.byte%0d", nm, k), mon_bytes[base + k], exp_byte(f, k));
      else
        check($sformatf("%s.byte%0d_missing", nm, k), mon_bytes.size(), base + k + 1);
    end
  endtask

  task automatic do_start(input logic [39:0] f, input logic [31:0] ip, input logic [15:0] p);
    start = 1'b1; frame = f; dst_ip = ip; dst_port = p;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      tick();
      if (!busy) got = 1'b1;
    end
    check({nm, ".idle_in_time"}, got, 1'b1);
    tick();
  endtask

  int          base, r0, d0, e0, cnt, nd, dA, dC;
  logic        seen, gap, ok, saw;
  logic [39:0] f, fa, fb, fc;
  logic [31:0] ip;
  logic [15:0] pt;

  initial begin
    rst = 1'b0; start = 1'b0; frame = '0; dst_ip = '0; dst_port = '0;
    tx_req_rdy_i = 1'b1; tx_data_rdy_i = 1'b1;
    repeat (3) tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.error", error, 0);
    check("rst.req", tx_req_o, 0);
    check("rst.av", tx_data_av_o, 0);
    check("rst.data", tx_data_o, 0);
    check("rst.ip", tx_ip_o, 0);
    check("rst.dport", tx_dst_port_o, 0);
    check("rst.sport", tx_src_port_o, 16'd2390);
    rst = 1'b1;
    tick();

    // Single frame, core always ready: row i gives outputs at cycle i+1.
    vt[0] = '{st:1, qr:1, dr:1, busy:1, av:0, chk_d:0, d:8'h00, req:0, done:0, err:0};
    vt[1] = '{st:0, qr:1, dr:1, busy:1, av:1, chk_d:1, d:8'h77, req:0, done:0, err:0};
    vt[2] = '{st:0, qr:1, dr:1, busy:1, av:1, chk_d:1, d:8'h69, req:0, done:0, err:0};
    vt[3] = '{st:0, qr:1, dr:1, busy:1, av:1, chk_d:1, d:8'h72, req:0, done:0, err:0};
    vt[4] = '{st:0, qr:1, dr:1, busy:1, av:1, chk_d:1, d:8'h74, req:0, done:0, err:0};
    vt[5] = '{st:0, qr:1, dr:1, busy:1, av:1, chk_d:1, d:8'h01, req:0, done:0, err:0};
    vt[6] = '{st:0, qr:1, dr:1, busy:1, av:0, chk_d:0, d:8'h00, req:1, done:0, err:0};
    vt[7] = '{st:0, qr:1, dr:1, busy:0, av:0, chk_d:0, d:8'h00, req:0, done:1, err:0};
    vt[8] = '{st:0, qr:1, dr:1, busy:0, av:0, chk_d:0, d:8'h00, req:0, done:0, err:0};
    frame = 40'h7769727401; dst_ip = 32'hC0A80A01; dst_port = 16'd5000;
    for (int i = 0; i < 9; i++) begin
      start = vt[i].st; tx_req_rdy_i = vt[i].qr; tx_data_rdy_i = vt[i].dr;
      tick();
      start = 1'b0;
      check($sformatf("vec%0d.busy", i), busy, vt[i].busy);
      check($sformatf("vec%0d.av", i), tx_data_av_o, vt[i].av);
      if (vt[i].chk_d) check($sformatf("vec%0d.data", i), tx_data_o, vt[i].d);
      check($sformatf("vec%0d.req", i), tx_req_o, vt[i].req);
      check($sformatf("vec%0d.done", i), done, vt[i].done);
      check($sformatf("vec%0d.error", i), error, vt[i].err);
      if (vt[i].req) begin
        check("vec.req_ip", tx_ip_o, 32'hC0A80A01);
        check("vec.req_port", tx_dst_port_o, 16'd5000);
      end
    end
    tick();

    // Backpressure: byte 2 held for three stalled cycles.
    base = mon_bytes.size(); r0 = n_reqacc; d0 = n_done;
    f = 40'hA1B2C3D4E5;
    do_start(f, 32'h0A000002, 16'd6000);
    repeat (3) tick();
    check("bp.byte2_shown", tx_data_o, 8'hC3);
    for (int i = 0; i < 3; i++) begin
      tx_data_rdy_i = 1'b0;
      tick();
      check("bp.hold_av", tx_data_av_o, 1);
      check("bp.hold_data", tx_data_o, 8'hC3);
    end
    tx_data_rdy_i = 1'b1;
    wait_idle("bp", 50);
    check("bp.count", mon_bytes.size() - base, NB);
    check_bytes("bp", base, f);
    check("bp.reqs", n_reqacc - r0, 1);
    check("bp.dones", n_done - d0, 1);

    // Timeout after byte 1.
    base = mon_bytes.size(); r0 = n_reqacc; e0 = n_err;
    f = 40'h1122334455;
    do_start(f, 32'h0A000003, 16'd6001);
    repeat (3) tick();
    check("to.byte2_shown", tx_data_o, 8'h33);
    tx_data_rdy_i = 1'b0;
    seen = 1'b0; cnt = 0;
    for (int i = 1; i <= 1100 && !seen; i++) begin
      tick();
      if (error) begin seen = 1'b1; cnt = i; end
    end
    check("to.seen", seen, 1);
    check("to.cycles", cnt, 1024);
    check("to.busy", busy, 0);
    check("to.av", tx_data_av_o, 0);
    tick();
    check("to.pulse", error, 0);
    tx_data_rdy_i = 1'b1;
    repeat (3) tick();
    check("to.reqs", n_reqacc - r0, 0);
    check("to.errs", n_err - e0, 1);
    check("to.count", mon_bytes.size() - base, 2);
    check("to.busy_after", busy, 0);

    // Pending slot: B overwritten by C, busy continuous.
    base = mon_bytes.size(); r0 = n_reqacc;
    fa = 40'hA0A1A2A3A4; fb = 40'hB0B1B2B3B4; fc = 40'hC0C1C2C3C4;
    do_start(fa, 32'h0A00000A, 16'd7000);
    gap = 1'b0; nd = 0; dA = 0; dC = 0;
    for (int c = 1; c < 60 && nd < 2; c++) begin
      if (done) begin
        nd++;
        if (nd == 1) dA = c; else dC = c;
      end
      if (!busy && nd < 2) gap = 1'b1;
      start = (c == 3) || (c == 5);
      if (c == 3) begin frame = fb; dst_ip = 32'h0A00000B; dst_port = 16'd7001; end
      if (c == 5) begin frame = fc; dst_ip = 32'h0A00000C; dst_port = 16'd7002; end
      tick();
    end
    start = 1'b0;
    tick();
    check("pend.busy_gap", gap, 0);
    check("pend.dones", nd, 2);
    check("pend.doneA_cycle", dA, 8);
    check("pend.doneC_cycle", dC, 16);
    check("pend.count", mon_bytes.size() - base, 2 * NB);
    check_bytes("pend.A", base, fa);
    check_bytes("pend.C", base + NB, fc);
    check("pend.reqs", n_reqacc - r0, 2);
    check("pend.ipC", req_ip, 32'h0A00000C);
    check("pend.portC", req_port, 16'd7002);

    // Reset during byte 3 with a frame pending.
    do_start(40'h0102030405, 32'h0A000004, 16'd6002);
    tick();
    start = 1'b1; frame = 40'h0607080910;
    tick();
    start = 1'b0;
    tick(); tick();
    check("rmid.byte3_shown", tx_data_o, 8'h04);
    r0 = n_reqacc; d0 = n_done;
    rst = 1'b0;
    tick();
    check("rmid.busy", busy, 0);
    check("rmid.done", done, 0);
    check("rmid.error", error, 0);
    check("rmid.req", tx_req_o, 0);
    check("rmid.av", tx_data_av_o, 0);
    check("rmid.data", tx_data_o, 0);
    check("rmid.ip", tx_ip_o, 0);
    check("rmid.dport", tx_dst_port_o, 0);
    check("rmid.sport", tx_src_port_o, 16'd2390);
    rst = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_req_o || done || busy) saw = 1'b1;
    end
    check("rmid.quiet_after", saw, 0);
    check("rmid.reqs", n_reqacc - r0, 0);
    check("rmid.dones", n_done - d0, 0);

    // Request gating in WAIT_RDY and in REQ.
    base = mon_bytes.size();
    f = 40'h5A5B5C5D5E;
    tx_req_rdy_i = 1'b0;
    do_start(f, 32'h0A000005, 16'd6003);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx_data_av_o || tx_req_o) saw = 1'b1;
      tick();
    end
    check("gate.wait_quiet", saw, 0);
    tx_req_rdy_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (tx_data_av_o) ok = 1'b1; else tick();
    end
    check("gate.load_started", ok, 1);
    tx_req_rdy_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (!tx_data_av_o) ok = 1'b1; else tick();
    end
    check("gate.bytes_done", ok, 1);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx_req_o || done) saw = 1'b1;
      tick();
    end
    check("gate.req_quiet", saw, 0);
    tx_req_rdy_i = 1'b1;
    tick();
    check("gate.req", tx_req_o, 1);
    check("gate.req_done", done, 0);
    check("gate.req_ip", tx_ip_o, 32'h0A000005);
    tick();
    check("gate.done", done, 1);
    check("gate.req_drop", tx_req_o, 0);
    check("gate.busy", busy, 0);
    tick();
    check("gate.count", mon_bytes.size() - base, NB);
    check_bytes("gate", base, f);

    // Randomised frames with random handshake stalls.
    for (int n = 0; n < 25; n++) begin
      f  = {8'($urandom), 32'($urandom)};
      ip = $urandom;
      pt = 16'($urandom);
      base = mon_bytes.size(); r0 = n_reqacc; e0 = n_err;
      tx_req_rdy_i  = ($urandom_range(3) != 0);
      tx_data_rdy_i = ($urandom_range(3) != 0);
      do_start(f, ip, pt);
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
        tx_req_rdy_i  = ($urandom_range(3) != 0);
        tx_data_rdy_i = ($urandom_range(3) != 0);
        if (done) ok = 1'b1; else tick();
      end
      tick();
      check($sformatf("rnd%0d.done", n), ok, 1);
      check($sformatf("rnd%0d.count", n), mon_bytes.size() - base, NB);
      check_bytes($sformatf("rnd%0d", n), base, f);
      check($sformatf("rnd%0d.reqs", n), n_reqacc - r0, 1);
      check($sformatf("rnd%0d.ip", n), req_ip, ip);
      check($sformatf("rnd%0d.port", n), req_port, pt);
      check($sformatf("rnd%0d.errs", n), n_err - e0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
